// File: rtl/multiplier.sv
// -----------------------------------------------------------------------------
// multiplier
// Radix-2 shift-add sequential multiplier for the RV32M multiply family
// (MUL, MULH, MULHSU, MULHU). Signed operands are converted to magnitudes
// on accept, multiplied unsigned over 32 CALC cycles into a 64-bit product,
// and the sign is re-applied in FIX before the selected half is registered.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous, active-high reset
//   start   request pulse, sampled only while busy=0
//   op      00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   a, b    operands (rs1, rs2), sampled with an accepted start
//   result  selected product half, held until the next result is produced
//   busy    high while an operation is in progress
//   done    one-cycle pulse, result valid in the same cycle
//
// Optional feature macro: MUL_ZERO_BYPASS_EN
//   When defined, an accepted start with a zero operand skips CALC/FIX and
//   completes through DONE with result 0.
// -----------------------------------------------------------------------------
module multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   mcand;
    logic [WIDTH-1:0] mplr;
    logic [PW-1:0]   prod;
    logic            neg;
    logic            hi_sel;

    logic            a_neg;
    logic            b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]   prod_fix;

    // Operand signedness and magnitudes; 0x80000000 negates to itself, which
    // read as unsigned is exactly the required magnitude 2^31.
    always_comb begin
        a_neg    = 1'b0;
        b_neg    = 1'b0;
        a_mag    = a;
        b_mag    = b;
        prod_fix = prod;
        a_neg    = (op != OP_MULHU) && a[WIDTH-1];
        b_neg    = ((op == OP_MUL) || (op == OP_MULH)) && b[WIDTH-1];
        if (a_neg) begin
            a_mag = ~a + WIDTH'(1);
        end
        if (b_neg) begin
            b_mag = ~b + WIDTH'(1);
        end
        if (neg) begin
            prod_fix = ~prod + PW'(1);
        end
    end

`ifdef MUL_ZERO_BYPASS_EN
    logic zero_op;

    always_comb begin
        zero_op = (a == '0) || (b == '0);
    end
`endif

    // Control FSM and datapath. done is registered off the DONE state, so the
    // pulse coincides with the return to IDLE and a new start can be taken on
    // the edge that ends the done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplr   <= '0;
            prod   <= '0;
            neg    <= 1'b0;
            hi_sel <= 1'b0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= PW'(a_mag);
                        mplr   <= b_mag;
                        prod   <= '0;
                        cnt    <= '0;
                        neg    <= a_neg ^ b_neg;
                        hi_sel <= (op != OP_MUL);
                        busy   <= 1'b1;
`ifdef MUL_ZERO_BYPASS_EN
                        if (zero_op) begin
                            result <= '0;
                            state  <= DONE;
                        end else begin
                            state  <= CALC;
                        end
`else
                        state  <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (mplr[0]) begin
                        prod <= prod + mcand;
                    end
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result <= hi_sel ? prod_fix[PW-1:WIDTH] : prod_fix[WIDTH-1:0];
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier.sv
// -----------------------------------------------------------------------------
// tb_multiplier
// Directed bench for the sequential multiplier: expected results are pushed
// to a scoreboard queue at stimulus time and popped when done pulses.
// -----------------------------------------------------------------------------
module tb_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int unsigned total;
    int unsigned bad;
    logic [31:0] sb[$];

`ifdef MUL_ZERO_BYPASS_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 34;
`endif

    multiplier #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sign/zero extend to 64 bits and keep the low 64 product bits.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        logic [63:0] xe;
        logic [63:0] ye;
        logic [63:0] p;
        xe = (o != 2'b11) ? {{32{x[31]}}, x} : {32'h0, x};
        ye = (o == 2'b00 || o == 2'b01) ? {{32{y[31]}}, y} : {32'h0, y};
        p  = xe * ye;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one operation, wait for done, check latency, busy, result and pulse width.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int exp_lat, input bit inject);
        int          cyc;
        bit          got;
        bit          busy_low;
        logic [31:0] expv;
        logic [31:0] held;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        sb.push_back(model(o, x, y));
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        cyc      = 0;
        got      = 1'b0;
        busy_low = (busy !== 1'b1);
        while (!got && cyc < 60) begin
            if (inject && cyc == 10) begin
                start = 1'b1;
                op    = 2'b00;
                a     = 32'h0000_0003;
                b     = 32'h0000_0005;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (done === 1'b1) begin
                got = 1'b1;
            end else if (busy !== 1'b1) begin
                busy_low = 1'b1;
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        if (got) begin
            expv = sb.pop_front();
            chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
            chk({tag, "_result"}, result, expv);
            chk({tag, "_busy_held"}, 32'(busy_low), 32'd0);
            chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            held = result;
            @(posedge clk);
            #1;
            chk({tag, "_done_width"}, 32'(done), 32'd0);
            chk({tag, "_result_hold"}, result, held);
        end else begin
            void'(sb.pop_front());
        end
    endtask

    initial begin
        int stray;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'h0;
        b     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 34, 1'b0);
        run_op("mulhu_ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b0);
        run_op("mulhsu_ff", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b0);
        run_op("mulh_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b0);
        run_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 34, 1'b0);
        run_op("mul_min_m1", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 34, 1'b0);
        run_op("mulhsu_min", 2'b10, 32'h8000_0000, 32'h8000_0000, 34, 1'b0);
        run_op("mul_inject", 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 34, 1'b1);
        run_op("mul_zero", 2'b00, 32'h0, 32'd5, ZERO_LAT, 1'b0);
        run_op("mulh_zero_b", 2'b01, 32'hDEAD_BEEF, 32'h0, ZERO_LAT, 1'b0);

        // Reset during CALC cycle 15, with a start raised alongside rst.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a     = 32'h7FFF_FFFF;
        b     = 32'h7FFF_FFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b1;
        a     = 32'h0000_0009;
        b     = 32'h0000_0009;
        @(posedge clk);
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", result, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        stray = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) stray++;
        end
        chk("midrst_no_activity", 32'(stray), 32'd0);

        run_op("after_rst", 2'b00, 32'hFFFF_FFF9, 32'd6, 34, 1'b0);

        for (int i = 0; i < 4; i++) begin
            run_op("random", 2'(i), $urandom, $urandom, 34, 1'b0);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 Port: clk  in  1  clock; all state changes on its rising edge.
REQ-003 Port: rst  in  1  reset, synchronous and active-high.
REQ-004 Port: start  in  1  request pulse; sampled only when busy=0.
REQ-005 Port: op  in  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-006 Port: a  in  32  multiplicand (rs1), sampled with start.
REQ-007 Port: b  in  32  multiplier (rs2), sampled with start.
REQ-008 Port: result  out  32  selected product half; held stable until next accepted start.
REQ-009 Port: busy  out  1  high while an operation is in progress (state != IDLE).
REQ-010 Port: done  out  1  one-cycle pulse; result valid in the same cycle.

Function
REQ-011 The block SHALL be a radix-2 shift-add sequential multiplier producing a full 64-bit product internally.
REQ-012 Operand signedness SHALL be: MUL/MULH a,b signed; MULHSU a signed, b unsigned; MULHU both unsigned.
REQ-013 Signed operands SHALL be converted to magnitude at accept; product sign = XOR of effective operand signs.
REQ-014 Result SHALL be product[31:0] for MUL, product[63:32] for MULH/MULHSU/MULHU.
REQ-015 States: IDLE, CALC, FIX, DONE.
REQ-016 IDLE: start=1 latches a, b, op; next state CALC; iteration counter loaded with 0.
REQ-017 CALC: each cycle adds the shifted multiplicand when the current multiplier bit is 1; counter increments; after the 32nd CALC cycle, next state FIX.
REQ-018 FIX: negate 64-bit product if sign flag set; load result register with selected half; next state DONE.
REQ-019 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-020 Latency: start accepted at edge k -> done high during cycle following edge k+34; next start accepted at edge k+35 earliest.
REQ-021 start while busy=1, including in DONE, SHALL be ignored; latched operands unchanged.
REQ-022 Operand inputs SHALL be don't-care except in the accept cycle.
REQ-023 0x80000000 operands SHALL multiply correctly (33-bit magnitude path, no overflow).

Reset
REQ-024 rst=1 at a rising edge SHALL force state IDLE, result=0, busy=0, done=0, counter=0, from any state.
REQ-025 Reset mid-operation SHALL abandon the operation; no done pulse is produced for it.
REQ-026 start asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-027 Macro MUL_ZERO_BYPASS_EN: when defined, an accepted start with a=0 or b=0 SHALL go IDLE -> DONE directly with result=0, done during cycle after edge k+1.
REQ-028 Without MUL_ZERO_BYPASS_EN, zero operands SHALL take the full 34-cycle path (REQ-020).

Verification
REQ-029 MUL a=7, b=6 -> result=0x0000002A, done exactly 34 cycles after the accept edge, busy high throughout.
REQ-030 MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU same operands -> 0xFFFFFFFF; MULH same operands -> 0x00000000.
REQ-031 MULH a=b=0x80000000 -> 0x40000000; MUL a=0x80000000, b=0xFFFFFFFF -> 0x80000000.
REQ-032 Second start pulse (different operands) at cycle 10 of an operation -> ignored; first result delivered unchanged, single done pulse.
REQ-033 rst at CALC cycle 15 -> next cycle busy=0, done=0, result=0; new start afterwards completes normally.
REQ-034 MUL a=0, b=5: with MUL_ZERO_BYPASS_EN -> result=0, done 1 cycle after accept; without -> result=0, done 34 cycles after accept.
